// File: rtl/alu_pkg.sv
// Shared ALU definitions: bitwise op encoding, serial-unit FSM states and a
// counter-width helper used by the digit-serial logic unit.
package alu_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  // A counter over n digits needs at least one bit even when n == 1.
  function automatic int cnt_width(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/nbit_logic_serial_if.sv
// Operand/result handshake bundle for nbit_logic_serial.
// Zero exists only when NBIT_LOGIC_SERIAL_ZERO_EN is defined.
interface nbit_logic_serial_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Result;
`ifdef NBIT_LOGIC_SERIAL_ZERO_EN
  logic             Zero;
`endif

  modport slave (
    input  in_valid, op, A, B, out_ready,
`ifdef NBIT_LOGIC_SERIAL_ZERO_EN
    output Zero,
`endif
    output in_ready, out_valid, Result
  );

  modport master (
    output in_valid, op, A, B, out_ready,
`ifdef NBIT_LOGIC_SERIAL_ZERO_EN
    input  Zero,
`endif
    input  in_ready, out_valid, Result
  );
endinterface

// File: rtl/nbit_logic_digit.sv
// Combinational AND/OR/XOR/NOR on one DIGIT-bit slice.
module nbit_logic_digit
  import alu_pkg::*;
#(
  parameter int DIGIT = 4
) (
  input  logic [1:0]       op,
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  output logic [DIGIT-1:0] y
);

  // slice operation select
  always_comb begin
    y = {DIGIT{1'b0}};
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NOR:  y = ~(a | b);
      default: y = {DIGIT{1'b0}};
    endcase
  end

endmodule

// File: rtl/nbit_logic_serial.sv
// Digit-serial bitwise logic unit: WIDTH-bit operands, DIGIT bits per clock.
// Optional Zero flag built with NBIT_LOGIC_SERIAL_ZERO_EN.
module nbit_logic_serial
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input logic                clk,
  input logic                rst_n,
  nbit_logic_serial_if.slave bus
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = cnt_width(NDIG);
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("nbit_logic_serial: DIGIT (%0d) must divide WIDTH (%0d)", DIGIT, WIDTH);
  end

  state_t           state_r;
  state_t           state_nx_s;
  logic [CW-1:0]    count_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [1:0]       op_r;
  logic [WIDTH-1:0] result_r;
  logic             out_valid_r;
  logic [DIGIT-1:0] digit_s;
  logic             accept_s;
  logic             last_s;

  assign bus.in_ready  = (state_r == S_IDLE) | ((state_r == S_DONE) & bus.out_ready);
  assign accept_s      = bus.in_valid & bus.in_ready;
  assign last_s        = (count_r == LAST);
  assign bus.out_valid = out_valid_r;
  assign bus.Result    = result_r;

  nbit_logic_digit #(.DIGIT(DIGIT)) u_digit (
    .op (op_r),
    .a  (a_r[DIGIT-1:0]),
    .b  (b_r[DIGIT-1:0]),
    .y  (digit_s)
  );

  // next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (bus.in_valid) state_nx_s = S_RUN;
        else              state_nx_s = S_IDLE;
      end
      S_RUN: begin
        if (last_s) state_nx_s = S_DONE;
        else        state_nx_s = S_RUN;
      end
      S_DONE: begin
        if (bus.out_ready) begin
          if (bus.in_valid) state_nx_s = S_RUN;
          else              state_nx_s = S_IDLE;
        end else begin
          state_nx_s = S_DONE;
        end
      end
      default: state_nx_s = S_IDLE;
    endcase
  end

  // state register; out_valid is registered off the next state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      out_valid_r <= (state_nx_s == S_DONE);
    end
  end

  // operand shift registers, result assembly from the MSB end, digit counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_r      <= {WIDTH{1'b0}};
      b_r      <= {WIDTH{1'b0}};
      op_r     <= OP_AND;
      count_r  <= {CW{1'b0}};
      result_r <= {WIDTH{1'b0}};
    end else if (accept_s) begin
      a_r      <= bus.A;
      b_r      <= bus.B;
      op_r     <= bus.op;
      count_r  <= {CW{1'b0}};
    end else if (state_r == S_RUN) begin
      a_r      <= a_r >> DIGIT;
      b_r      <= b_r >> DIGIT;
      result_r <= (result_r >> DIGIT) | (WIDTH'(digit_s) << (WIDTH - DIGIT));
      if (!last_s) count_r <= count_r + 1'b1;
      else         count_r <= count_r;
    end else begin
      a_r      <= a_r;
    end
  end

`ifdef NBIT_LOGIC_SERIAL_ZERO_EN
  logic zero_r;

  // zero_r stays set only while every computed digit has been all-zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      zero_r <= 1'b0;
    end else if (accept_s) begin
      zero_r <= 1'b1;
    end else if (state_r == S_RUN) begin
      zero_r <= zero_r & ~(|digit_s);
    end else begin
      zero_r <= zero_r;
    end
  end

  assign bus.Zero = zero_r;
`endif

endmodule

// File: tb/tb_nbit_logic_serial.sv
// Self-checking bench for nbit_logic_serial (DIGIT=4 and DIGIT=32 instances),
// scoreboard-based, directed steps followed by a random streaming phase.
module tb_nbit_logic_serial;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  nbit_logic_serial_if #(.WIDTH(32)) bus  ();
  nbit_logic_serial_if #(.WIDTH(32)) bus1 ();

  nbit_logic_serial #(.WIDTH(32), .DIGIT(4)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  nbit_logic_serial #(.WIDTH(32), .DIGIT(32)) u_dut32 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] e;
  int          lat;
  int          sent;
  int          rcvd;
  int          cyc;

  function automatic logic [31:0] ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_out(input int maxc, output int l);
    l = 0;
    while (bus.out_valid !== 1'b1 && l < maxc) begin
      tick();
      l++;
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.A        = a;
    bus.B        = b;
    #1;
    check("in_ready_at_accept", 32'(bus.in_ready), 32'd1);
    tick();
    exp_q.push_back(ref_op(op, a, b));
    bus.in_valid = 1'b0;
  endtask

  task automatic pop_exp(output logic [31:0] v);
    check("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) v = exp_q.pop_front();
    else                  v = 32'hxxxx_xxxx;
  endtask

  task automatic consume(input string tag);
    logic [31:0] v;
    check("out_valid_before_consume", 32'(bus.out_valid), 32'd1);
    pop_exp(v);
    check(tag, bus.Result, v);
`ifdef NBIT_LOGIC_SERIAL_ZERO_EN
    check("zero_flag", 32'(bus.Zero), 32'(v == 32'd0));
`endif
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("out_valid_after_consume", 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.op        = 2'b00;
    bus.A         = 32'd0;
    bus.B         = 32'd0;
    bus1.in_valid  = 1'b0;
    bus1.out_ready = 1'b0;
    bus1.op        = 2'b00;
    bus1.A         = 32'd0;
    bus1.B         = 32'd0;
    rst_n = 1'b0;
    tick();
    tick();

    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_result", bus.Result, 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst32_out_valid", 32'(bus1.out_valid), 32'd0);
`ifdef NBIT_LOGIC_SERIAL_ZERO_EN
    check("rst_zero", 32'(bus.Zero), 32'd0);
`endif
    rst_n = 1'b1;
    tick();

    // 1: AND with latency check
    send(OP_AND, 32'hF0F0_1234, 32'h0FF0_FFFF);
    check("run_out_valid_low", 32'(bus.out_valid), 32'd0);
    check("run_in_ready_low", 32'(bus.in_ready), 32'd0);
    wait_out(20, lat);
    check("and_latency", 32'(lat), 32'd8);
    consume("and_result");

    // 2: XOR to zero, NOR of zeros
    send(OP_XOR, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_out(20, lat);
    consume("xor_result");
    send(OP_NOR, 32'h0000_0000, 32'h0000_0000);
    wait_out(20, lat);
    consume("nor_result");

    // 3: backpressure then back-to-back accept
    send(OP_AND, 32'hDEAD_BEEF, 32'h0000_FFFF);
    wait_out(20, lat);
    check("bp_latency", 32'(lat), 32'd8);
    for (int i = 0; i < 20; i++) begin
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_result", bus.Result, 32'h0000_BEEF);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      tick();
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.op        = OP_OR;
    bus.A         = 32'h0000_0001;
    bus.B         = 32'h8000_0000;
    #1;
    check("b2b_in_ready", 32'(bus.in_ready), 32'd1);
    pop_exp(e);
    check("bp_result_at_release", bus.Result, e);
    tick();
    exp_q.push_back(ref_op(OP_OR, 32'h0000_0001, 32'h8000_0000));
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("b2b_out_valid_low", 32'(bus.out_valid), 32'd0);
    wait_out(20, lat);
    check("b2b_latency", 32'(lat), 32'd8);
    consume("b2b_result");

    // 4: reset during RUN discards the pending op
    send(OP_OR, 32'h1234_5678, 32'h8765_4321);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_result", bus.Result, 32'd0);
    for (int i = 0; i < 12; i++) tick();
    check("midrst_no_stale", 32'(bus.out_valid), 32'd0);

    // 5: inputs toggled during RUN have no effect
    send(OP_XOR, 32'h1234_5678, 32'h0F0F_F0F0);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 20) begin
      bus.in_valid = 1'($urandom_range(1));
      bus.op       = 2'($urandom_range(3));
      bus.A        = $urandom();
      bus.B        = $urandom();
      tick();
      lat++;
    end
    bus.in_valid = 1'b0;
    check("toggle_latency", 32'(lat), 32'd8);
    consume("toggle_result");

    // 6: DIGIT == WIDTH, single RUN cycle
    bus1.in_valid = 1'b1;
    bus1.op       = OP_AND;
    bus1.A        = 32'hA5A5_A5A5;
    bus1.B        = 32'hFFFF_0000;
    #1;
    check("d32_in_ready", 32'(bus1.in_ready), 32'd1);
    tick();
    bus1.in_valid = 1'b0;
    lat = 0;
    while (bus1.out_valid !== 1'b1 && lat < 10) begin
      tick();
      lat++;
    end
    check("d32_latency", 32'(lat), 32'd1);
    check("d32_result", bus1.Result, 32'hA5A5_0000);
    bus1.out_ready = 1'b1;
    tick();
    bus1.out_ready = 1'b0;
    check("d32_out_valid_after", 32'(bus1.out_valid), 32'd0);

    // random streaming vs reference model
    sent = 0;
    rcvd = 0;
    cyc  = 0;
    while ((sent < 1000 || rcvd < sent) && cyc < 40000) begin
      bus.in_valid  = (sent < 1000) && ($urandom_range(3) != 0);
      bus.op        = 2'($urandom_range(3));
      bus.A         = $urandom();
      bus.B         = $urandom();
      bus.out_ready = ($urandom_range(3) != 0);
      #1;
      if (bus.out_valid && bus.out_ready) begin
        pop_exp(e);
        check("rand_result", bus.Result, e);
`ifdef NBIT_LOGIC_SERIAL_ZERO_EN
        check("rand_zero", 32'(bus.Zero), 32'(e == 32'd0));
`endif
        rcvd++;
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(ref_op(bus.op, bus.A, bus.B));
        sent++;
      end
      tick();
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("rand_sent", 32'(sent), 32'd1000);
    check("rand_rcvd", 32'(rcvd), 32'd1000);
    check("rand_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
